// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: address width, HALT opcode and FSM state encodings.
// Pure declarations; no latency or backpressure of its own.
package instruction_fetch_pkg;

    localparam int          ADDRWIDTH   = 32;
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, load and fetch-output bundle of the fetch stage.
// Slave is the fetch stage; master is whatever steers it (debug unit, hazard/branch logic).
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int NB_DATA = 32
);
    logic                 enable_pipe_i;
    logic                 stall_i;
    logic                 branch_taken_i;
    logic [ADDRWIDTH-1:0] branch_addr_i;
    logic                 jump_i;
    logic [ADDRWIDTH-1:0] jump_addr_i;
    logic                 load_en_i;
    logic [ADDRWIDTH-1:0] load_addr_i;
    logic [NB_DATA-1:0]   load_data_i;
    logic                 load_done_i;
    logic [ADDRWIDTH-1:0] pc_o;
    logic [NB_DATA-1:0]   instruction_o;
    logic                 halted_o;

    modport master (
        output enable_pipe_i, stall_i, branch_taken_i, branch_addr_i, jump_i, jump_addr_i,
        output load_en_i, load_addr_i, load_data_i, load_done_i,
        input  pc_o, instruction_o, halted_o
    );

    modport slave (
        input  enable_pipe_i, stall_i, branch_taken_i, branch_addr_i, jump_i, jump_addr_i,
        input  load_en_i, load_addr_i, load_data_i, load_done_i,
        output pc_o, instruction_o, halted_o
    );
endinterface

// File: rtl/instruction_memory.sv
// Instruction store: write lands on posedge, read is combinational from the address.
// No backpressure; contents are deliberately not reset so a program survives a core reset.
module instruction_memory #(
    parameter  int NB_DATA   = 32,
    parameter  int MEM_DEPTH = 256,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic               clock_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [NB_DATA-1:0] wdata_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [NB_DATA-1:0] rdata_o
);
    logic [NB_DATA-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, next-PC mux and LOAD/RUN/HALTED control; word and PC+4 valid same cycle.
// No handshake: enable_pipe_i and stall_i hold the PC; redirects take effect on the next posedge.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                clock_i,
    input  logic                reset_i,
    instruction_fetch_if.slave  fetch_if
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    fetch_state_e         state_q, state_d;
    logic [ADDRWIDTH-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0]   mem_word;
    logic                 mem_we;
    logic                 is_halt;

    assign mem_we  = (state_q == ST_LOAD) && fetch_if.load_en_i;
    assign is_halt = (mem_word == {NB_DATA{1'b1}});

    instruction_memory #(
        .NB_DATA   (NB_DATA),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_imem (
        .clock_i (clock_i),
        .we_i    (mem_we),
        .waddr_i (fetch_if.load_addr_i[IDX_W-1:0]),
        .wdata_i (fetch_if.load_data_i),
        .raddr_i (pc_q[IDX_W+1:2]),
        .rdata_o (mem_word)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirects outrank the HALT check so a HALT on the wrong path never stops the core.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_LOAD: begin
                pc_d = '0;
                if (fetch_if.load_done_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_if.enable_pipe_i) begin
                    if (fetch_if.branch_taken_i) begin
                        pc_d = fetch_if.branch_addr_i;
                    end else if (fetch_if.jump_i) begin
                        pc_d = fetch_if.jump_addr_i;
                    end else if (fetch_if.stall_i) begin
                        pc_d = pc_q;
                    end else if (is_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + ADDRWIDTH'(4);
                    end
                end
            end
            ST_HALTED: begin
                pc_d = pc_q;
            end
            default: begin
                state_d = ST_LOAD;
                pc_d    = '0;
            end
        endcase
    end

    assign fetch_if.pc_o          = pc_q + ADDRWIDTH'(4);
    assign fetch_if.instruction_o = (state_q == ST_LOAD) ? '0 : mem_word;
    assign fetch_if.halted_o      = (state_q == ST_HALTED);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run/halt, stall, redirect priority, wrap, reset.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    instruction_fetch_if #(.NB_DATA(32)) fif ();

    instruction_fetch #(.NB_DATA(32), .MEM_DEPTH(256)) dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .fetch_if (fif)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        en;
        logic        st;
        logic        br;
        logic [31:0] ba;
        logic        jp;
        logic [31:0] ja;
        logic        ld;
        logic [31:0] ldat;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ehalt;
    } vec_t;

    vec_t tbl [22];

    function automatic logic [31:0] w(input int i);
        return (i == 5) ? HALT_OPCODE : 32'h2000_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic en, input logic st, input logic br, input logic [31:0] ba,
                                input logic jp, input logic [31:0] ja, input logic ld,
                                input logic [31:0] epc, input logic [31:0] einst, input logic ehalt);
        vec_t v;
        v.en = en; v.st = st; v.br = br; v.ba = ba; v.jp = jp; v.ja = ja;
        v.ld = ld; v.ldat = 32'hDEAD_BEEF;
        v.epc = epc; v.einst = einst; v.ehalt = ehalt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                              input logic ehalt);
        check({tag, ".pc_o"}, fif.pc_o, epc);
        check({tag, ".instr"}, fif.instruction_o, einst);
        check({tag, ".halted"}, {31'd0, fif.halted_o}, {31'd0, ehalt});
    endtask

    task automatic idle_inputs();
        fif.enable_pipe_i  = 1'b1;
        fif.stall_i        = 1'b0;
        fif.branch_taken_i = 1'b0;
        fif.branch_addr_i  = '0;
        fif.jump_i         = 1'b0;
        fif.jump_addr_i    = '0;
        fif.load_en_i      = 1'b0;
        fif.load_addr_i    = '0;
        fif.load_data_i    = '0;
        fif.load_done_i    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #1 reset_i = 1'b1;
        #1 check_outs("reset_async", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        #1 check_outs("reset_release", 32'd4, 32'd0, 1'b0);

        // Program 1: load then run into HALT; last write shares its cycle with load_done.
        @(negedge clock_i);
        fif.load_en_i = 1'b1; fif.load_addr_i = 32'd0; fif.load_data_i = 32'h2001_0005;
        #1 check_outs("load_nop", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        fif.load_addr_i = 32'd1; fif.load_data_i = 32'h2002_0003;
        @(negedge clock_i);
        fif.load_addr_i = 32'd2; fif.load_data_i = HALT_OPCODE; fif.load_done_i = 1'b1;
        #1 check_outs("load_done_cycle", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        idle_inputs();
        #1 check_outs("p1_w0", 32'd4, 32'h2001_0005, 1'b0);
        @(negedge clock_i);
        #1 check_outs("p1_w1", 32'd8, 32'h2002_0003, 1'b0);
        @(negedge clock_i);
        #1 check_outs("p1_halt_fetch", 32'd12, HALT_OPCODE, 1'b0);
        @(negedge clock_i);
        fif.jump_i = 1'b1; fif.jump_addr_i = 32'd0;
        #1 check_outs("p1_halted", 32'd12, HALT_OPCODE, 1'b1);
        @(negedge clock_i);
        fif.jump_i = 1'b0;
        #1 check_outs("p1_halted_frozen", 32'd12, HALT_OPCODE, 1'b1);

        @(negedge clock_i);
        reset_i = 1'b1;
        #1 check_outs("reset_from_halted", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Program 2: fill the whole memory; index 3 is written through an out-of-range address.
        for (int i = 0; i < 256; i++) begin
            @(negedge clock_i);
            fif.load_en_i   = 1'b1;
            fif.load_addr_i = (i == 3) ? 32'h0000_0103 : 32'(i);
            fif.load_data_i = w(i);
        end
        @(negedge clock_i);
        fif.load_en_i = 1'b0; fif.load_done_i = 1'b1;

        tbl[0]  = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h4,        w(0),   0);
        tbl[1]  = mk(1,1,0,32'h0,  0,32'h0,          0, 32'h8,        w(1),   0);
        tbl[2]  = mk(1,1,0,32'h0,  0,32'h0,          0, 32'h8,        w(1),   0);
        tbl[3]  = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h8,        w(1),   0);
        tbl[4]  = mk(1,0,0,32'h0,  0,32'h0,          0, 32'hC,        w(2),   0);
        tbl[5]  = mk(0,0,0,32'h0,  0,32'h0,          0, 32'h10,       w(3),   0);
        tbl[6]  = mk(0,0,1,32'h100,0,32'h0,          0, 32'h10,       w(3),   0);
        tbl[7]  = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h10,       w(3),   0);
        tbl[8]  = mk(1,1,1,32'h40, 1,32'h80,         0, 32'h14,       w(4),   0);
        tbl[9]  = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h44,       w(16),  0);
        tbl[10] = mk(1,1,0,32'h0,  1,32'h14,         0, 32'h48,       w(17),  0);
        tbl[11] = mk(1,0,1,32'h0,  0,32'h0,          0, 32'h18,       w(5),   0);
        tbl[12] = mk(1,0,0,32'h0,  0,32'h0,          1, 32'h4,        w(0),   0);
        tbl[13] = mk(1,0,0,32'h0,  1,32'h400,        0, 32'h8,        w(1),   0);
        tbl[14] = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h404,      w(0),   0);
        tbl[15] = mk(1,0,0,32'h0,  1,32'hFFFF_FFFC,  0, 32'h408,      w(1),   0);
        tbl[16] = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h0,        w(255), 0);
        tbl[17] = mk(1,0,0,32'h0,  1,32'h14,         0, 32'h4,        w(0),   0);
        tbl[18] = mk(1,1,0,32'h0,  0,32'h0,          0, 32'h18,       w(5),   0);
        tbl[19] = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h18,       w(5),   0);
        tbl[20] = mk(1,0,1,32'h0,  0,32'h0,          0, 32'h18,       w(5),   1);
        tbl[21] = mk(1,0,0,32'h0,  0,32'h0,          0, 32'h18,       w(5),   1);

        for (int r = 0; r < 22; r++) begin
            @(negedge clock_i);
            idle_inputs();
            fif.enable_pipe_i  = tbl[r].en;
            fif.stall_i        = tbl[r].st;
            fif.branch_taken_i = tbl[r].br;
            fif.branch_addr_i  = tbl[r].ba;
            fif.jump_i         = tbl[r].jp;
            fif.jump_addr_i    = tbl[r].ja;
            fif.load_en_i      = tbl[r].ld;
            fif.load_data_i    = tbl[r].ldat;
            #1 check_outs($sformatf("row%0d", r), tbl[r].epc, tbl[r].einst, tbl[r].ehalt);
        end

        // Restart from HALTED with the retained program, then reset mid-run at PC=12.
        @(negedge clock_i);
        idle_inputs();
        reset_i = 1'b1;
        #1 check_outs("reset_p2_halted", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        reset_i = 1'b0; fif.load_done_i = 1'b1;
        @(negedge clock_i);
        fif.load_done_i = 1'b0;
        #1 check_outs("rerun_w0", 32'd4, w(0), 1'b0);
        @(negedge clock_i);
        #1 check_outs("rerun_w1", 32'd8, w(1), 1'b0);
        @(negedge clock_i);
        #1 check_outs("rerun_w2", 32'd12, w(2), 1'b0);
        @(negedge clock_i);
        #1 check_outs("rerun_w3", 32'd16, w(3), 1'b0);
        #1 reset_i = 1'b1;
        #1 check_outs("reset_mid_run", 32'd4, 32'd0, 1'b0);
        @(negedge clock_i);
        reset_i = 1'b0; fif.load_done_i = 1'b1;
        @(negedge clock_i);
        fif.load_done_i = 1'b0;
        #1 check_outs("restart_w0", 32'd4, w(0), 1'b0);
        @(negedge clock_i);
        #1 check_outs("restart_w1", 32'd8, w(1), 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_i);
            fif.enable_pipe_i = 1'b0;
            #1 check_outs($sformatf("enable_hold%0d", k), 32'd12, w(2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipelined MIPS core. It owns the program counter, the instruction memory, and the load/run/halt control of the fetch path. Each cycle it presents the fetched word and PC+4 to the IF/ID pipeline register. The debug unit fills the memory before execution, and hazard/branch logic from later stages steers the PC.

## Interface
Parameters:
- NB_DATA, 32, instruction word width
- MEM_DEPTH, 256, instruction memory depth in words (power of two)

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- enable_pipe_i  in  1  global pipeline enable (debug step/run); 0 freezes the PC
- stall_i  in  1  load-use stall from hazard unit; holds PC
- branch_taken_i  in  1  taken-branch redirect
- branch_addr_i  in  `ADDRWIDTH  branch target byte address
- jump_i  in  1  jump redirect
- jump_addr_i  in  `ADDRWIDTH  jump target byte address
- load_en_i  in  1  program word write strobe
- load_addr_i  in  `ADDRWIDTH  word index to write
- load_data_i  in  NB_DATA  program word
- load_done_i  in  1  program load complete
- pc_o  out  `ADDRWIDTH  PC+4 of the fetched instruction
- instruction_o  out  NB_DATA  fetched instruction
- halted_o  out  1  HALT fetched; fetch frozen

## Operation
- States: LOAD (reset state), RUN, HALTED.
  - LOAD -> RUN on load_done_i.
  - RUN -> HALTED on HALT fetch (see below).
  - HALTED exits only via reset_i.
- LOAD:
  - load_en_i writes load_data_i to mem[load_addr_i mod MEM_DEPTH].
  - PC held at 0; instruction_o = 0 (NOP).
  - load_en_i and load_done_i in the same cycle: the write completes, then the state moves to RUN.
- RUN:
  - load_en_i is ignored.
  - instruction_o = mem[PC[log2(MEM_DEPTH)+1:2]]. PC bits [1:0] are ignored and the index wraps modulo MEM_DEPTH.
- PC next-value priority, RUN only:
  1. enable_pipe_i=0: hold.
  2. branch_taken_i: branch_addr_i.
  3. jump_i: jump_addr_i.
  4. stall_i: hold.
  5. Otherwise: PC+4, wrapping modulo 2^`ADDRWIDTH.
- Branch beats jump because the branch comes from an older instruction. Any redirect beats a stall.
- HALT (all ones, NB_DATA'hFFFFFFFF) fetched with enable_pipe_i=1, stall_i=0 and no redirect:
  - go to HALTED; PC frozen at the HALT address; halted_o=1.
  - instruction_o stays HALT so the word drains through the pipe.
- HALT fetched while a redirect is active: it is a wrong-path fetch. Take the redirect and do not halt.
- HALT fetched during a stall: the halt is deferred until the stall releases.
- Memory contents are not cleared by reset.

## Timing
- PC and state update on posedge clock_i. The memory read is combinational from PC, so a word is valid well before the IF/ID register captures on negedge.
- pc_o = PC+4 combinationally.
- A memory write lands on posedge and is readable the following cycle.
- Reset values (asynchronous, immediate): state=LOAD, PC=0, pc_o=4, instruction_o=0, halted_o=0.
- Reset mid-RUN or in HALTED: returns to LOAD at once. The program is retained, and load_done_i alone restarts execution from address 0.
- Redirect latency: a target asserted before posedge N is fetched in cycle N.

## Structure
- Shared header parameters.vh holds `ADDRWIDTH, the HALT opcode constant and the state encodings (2 bits).
- Sub-module instruction_memory contains the storage:
  - synchronous write port;
  - asynchronous read port;
  - parameters NB_DATA and MEM_DEPTH.
- PC, next-PC mux and FSM live in instruction_fetch.

## Test plan
- Load then run: write words 0x20010005, 0x20020003, 0xFFFFFFFF at indices 0–2, then pulse load_done_i. Expect instruction_o to step through the three words with pc_o = 4, 8, 12, then halted_o=1 with PC held at 8.
- Stall: assert stall_i for 2 cycles at PC=4. PC and instruction_o hold for 2 cycles, then the fetch resumes at 8.
- Simultaneous redirects at PC=16: branch_taken_i with branch_addr_i=0x40, together with jump_i with jump_addr_i=0x80, plus stall_i. The next PC is 0x40.
- Wrong-path HALT: HALT at index 5 and a branch to 0x0 asserted while PC=20. No halt occurs and the fetch continues at 0.
- Reset mid-run and enable gating:
  - Assert reset_i asynchronously at PC=12. PC=0, pc_o=4, instruction_o=0 and state=LOAD immediately.
  - After load_done_i, the old program runs again.
  - With enable_pipe_i=0, PC never moves.
- Wrap and ignored load: with MEM_DEPTH=256, PC=0x400 fetches index 0. A load_en_i pulse in RUN leaves memory unchanged.
